// File: rtl/phys_regfile_mp.sv
// phys_regfile_mp: multi-ported physical register file with speculative and
// architectural valid bits, committed condition flags and a post-reset scrub.
// Issue reads operands here, functional units write results here, and the
// ROB frees/commits registers, updates flags and triggers mispredict rollback.
// Optional feature macro: PHYS_REGFILE_BYPASS_EN forwards same-cycle exe
// writes straight to the read ports; without it reads see registered state.

module phys_regfile_mp #(
    parameter int WORD_SIZE_P    = 16,
    parameter int NUM_PHYS_REG_P = 128,
    parameter int NUM_ARCH_REG_P = 16,
    parameter int NUM_WR_P       = 3,
    parameter int NUM_RD_P       = 4,
    parameter int NUM_CMT_P      = 2,
    parameter int NUM_FLAGS_P    = 4,
    parameter int INIT_PER_CYC_P = 8
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_n_i,
    output logic                                                  ready_o,
    input  logic [NUM_WR_P-1:0]                                   exe_w_v_i,
    input  logic [NUM_WR_P-1:0][$clog2(NUM_PHYS_REG_P)-1:0]       exe_addr_i,
    input  logic [NUM_WR_P-1:0][WORD_SIZE_P-1:0]                  exe_data_i,
    input  logic [NUM_CMT_P-1:0]                                  cmt_v_i,
    input  logic [NUM_CMT_P-1:0][$clog2(NUM_PHYS_REG_P)-1:0]      cmt_phys_cl_i,
    input  logic [NUM_CMT_P-1:0][$clog2(NUM_PHYS_REG_P)-1:0]      cmt_phys_set_i,
    input  logic                                                  mispredict_i,
    input  logic                                                  flag_v_i,
    input  logic [2*NUM_FLAGS_P-1:0]                              flag_i,
    output logic [NUM_FLAGS_P-1:0]                                flag_o,
    input  logic [NUM_RD_P-1:0][$clog2(NUM_PHYS_REG_P)-1:0]       rd_addr_i,
    output logic [NUM_RD_P-1:0]                                   rd_valid_o,
    output logic [NUM_RD_P-1:0][WORD_SIZE_P-1:0]                  rd_data_o
);

    localparam int AW      = $clog2(NUM_PHYS_REG_P);
    localparam int NUM_BLK = NUM_PHYS_REG_P / INIT_PER_CYC_P;
    localparam int CW      = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;

    localparam logic [CW-1:0] LAST_BLK = CW'(NUM_BLK - 1);

    // Architectural registers p0..p(N-1) hold valid values straight out of reset
    localparam logic [NUM_PHYS_REG_P-1:0] RESET_VALID =
        {NUM_PHYS_REG_P{1'b1}} >> (NUM_PHYS_REG_P - NUM_ARCH_REG_P);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                    state_q;
    logic [CW-1:0]             scrubCnt_q;
    logic                      ready_q;
    logic [NUM_PHYS_REG_P-1:0] valid_q;
    logic [NUM_PHYS_REG_P-1:0] valid_d;
    logic [NUM_PHYS_REG_P-1:0] validArch_q;
    logic [NUM_PHYS_REG_P-1:0] validArch_d;
    logic [NUM_FLAGS_P-1:0]    flag_q;
    logic [NUM_FLAGS_P-1:0]    flag_d;
    logic [NUM_FLAGS_P-1:0]    flagMask;
    logic [NUM_FLAGS_P-1:0]    flagValue;
    logic [WORD_SIZE_P-1:0]    data_q [NUM_PHYS_REG_P];

    assign flagMask  = flag_i[2*NUM_FLAGS_P-1:NUM_FLAGS_P];
    assign flagValue = flag_i[NUM_FLAGS_P-1:0];

    // Next valid bits: exe sets, then commit slots in order, then mispredict rollback
    always_comb begin
        valid_d     = valid_q;
        validArch_d = validArch_q;
        for (int w = 0; w < NUM_WR_P; w++) begin
            if (exe_w_v_i[w]) begin
                valid_d[exe_addr_i[w]] = 1'b1;
            end
        end
        for (int c = 0; c < NUM_CMT_P; c++) begin
            if (cmt_v_i[c]) begin
                valid_d[cmt_phys_cl_i[c]]      = 1'b0;
                validArch_d[cmt_phys_cl_i[c]]  = 1'b0;
                validArch_d[cmt_phys_set_i[c]] = 1'b1;
            end
        end
        if (mispredict_i) begin
            valid_d = validArch_d;
        end
    end

    // Masked flag merge: masked bits take the new value, others keep the old one
    always_comb begin
        flag_d = flag_q;
        if (flag_v_i) begin
            flag_d = (flagMask & flagValue) | (~flagMask & flag_q);
        end
    end

    // Control FSM: walk the scrub blocks in INIT, then track valids and flags in RUN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_INIT;
            scrubCnt_q  <= '0;
            ready_q     <= 1'b0;
            valid_q     <= RESET_VALID;
            validArch_q <= RESET_VALID;
            flag_q      <= '0;
        end else if (state_q == ST_INIT) begin
            scrubCnt_q <= scrubCnt_q + CW'(1);
            if (scrubCnt_q == LAST_BLK) begin
                state_q <= ST_RUN;
                ready_q <= 1'b1;
            end
        end else begin
            valid_q     <= valid_d;
            validArch_q <= validArch_d;
            flag_q      <= flag_d;
        end
    end

    // Data storage: one register per entry, no reset because the scrub zeroes it
    for (genvar e = 0; e < NUM_PHYS_REG_P; e++) begin : g_entry
        // Scrub this entry when its block comes up, otherwise take the highest-index exe write
        always_ff @(posedge clk_i) begin
            if (state_q == ST_INIT) begin
                if (scrubCnt_q == CW'(e / INIT_PER_CYC_P)) begin
                    data_q[e] <= '0;
                end
            end else begin
                for (int w = 0; w < NUM_WR_P; w++) begin
                    if (exe_w_v_i[w] && (exe_addr_i[w] == AW'(e))) begin
                        data_q[e] <= exe_data_i[w];
                    end
                end
            end
        end
    end

    // Read ports: registered state in RUN, optionally overridden by same-cycle exe writes
    always_comb begin
        rd_valid_o = '0;
        rd_data_o  = '0;
        if (state_q == ST_RUN) begin
            for (int r = 0; r < NUM_RD_P; r++) begin
                rd_valid_o[r] = valid_q[rd_addr_i[r]];
                rd_data_o[r]  = data_q[rd_addr_i[r]];
`ifdef PHYS_REGFILE_BYPASS_EN
                for (int w = 0; w < NUM_WR_P; w++) begin
                    if (exe_w_v_i[w] && (exe_addr_i[w] == rd_addr_i[r])) begin
                        rd_valid_o[r] = 1'b1;
                        rd_data_o[r]  = exe_data_i[w];
                    end
                end
`else
                for (int w = 0; w < NUM_WR_P; w++) begin
                    rd_valid_o[r] = rd_valid_o[r];
                end
`endif
            end
        end
    end

    assign ready_o = ready_q;
    assign flag_o  = flag_q;

endmodule

// File: doc/phys_regfile_mp.md
# phys_regfile_mp

Parametrised, multi-ported physical register file with speculative and architectural valid tracking, and committed condition flags. It sits between issue and commit and replaces the single-commit, two-read-port register state. It adds configurable read, write and commit widths, and a multi-cycle post-reset data scrub. Issue reads operands here, functional units write results here, and the ROB frees and commits physical registers, updates flags and triggers misprediction rollback here.

## Interface
- WORD_SIZE_P, 16, data word width
- NUM_PHYS_REG_P, 128, physical registers (power of 2)
- NUM_ARCH_REG_P, 16, registers valid out of reset (p0..p(N-1))
- NUM_WR_P, 3, FU write-back ports
- NUM_RD_P, 4, issue read ports
- NUM_CMT_P, 2, commit slots per cycle
- NUM_FLAGS_P, 4, flag bits
- INIT_PER_CYC_P, 8, entries scrubbed per INIT cycle; must divide NUM_PHYS_REG_P
- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous active-low reset
- ready_o  out  1  high in RUN; low during INIT
- exe_w_v_i  in  NUM_WR_P  per-FU write valid
- exe_addr_i  in  NUM_WR_P x log2(NUM_PHYS_REG_P)  write address
- exe_data_i  in  NUM_WR_P x WORD_SIZE_P  write data
- cmt_v_i  in  NUM_CMT_P  commit slot valid
- cmt_phys_cl_i  in  NUM_CMT_P x log2(NUM_PHYS_REG_P)  register freed by commit
- cmt_phys_set_i  in  NUM_CMT_P x log2(NUM_PHYS_REG_P)  register made architectural
- mispredict_i  in  1  roll speculative valids back to architectural
- flag_v_i  in  1  flag update valid
- flag_i  in  2*NUM_FLAGS_P  {mask, value}
- flag_o  out  NUM_FLAGS_P  committed flags
- rd_addr_i  in  NUM_RD_P x log2(NUM_PHYS_REG_P)  read addresses
- rd_valid_o  out  NUM_RD_P  operand ready
- rd_data_o  out  NUM_RD_P x WORD_SIZE_P  operand data

## Operation
- **Reset** (asynchronous, reset_n_i=0):
  - state=INIT, scrub counter=0, ready_o=0.
  - valid and valid_arch = ones in the low NUM_ARCH_REG_P bits, zeros elsewhere.
  - flags=0.
  - Data array is not reset; the INIT scrub clears it.
- **INIT:**
  - Each cycle writes zero to entries counter*INIT_PER_CYC_P .. +INIT_PER_CYC_P-1, then increments the counter.
  - After the last block, the next state is RUN.
  - All write, commit, flag and mispredict inputs are ignored.
  - rd_valid_o=0 and rd_data_o=0 on all ports.
- **RUN, exe writes:**
  - data[addr]=data_in and valid[addr]=1 for each asserted exe_w_v_i.
  - When several ports hit the same address, the highest index wins.
- **RUN, commit:** slots are processed in index order; later slots override earlier ones.
  - valid[cl]=0, valid_arch[cl]=0, valid_arch[set]=1.
  - A commit clear beats a same-cycle exe write valid on the same register; the data is still written.
- **RUN, mispredict:**
  - valid_next = valid_arch_next, which includes same-cycle commits.
  - All same-cycle exe valid sets are discarded; data writes still occur.
- **RUN, flags:** when flag_v_i=1, flag_next = (mask & value) | (~mask & flag).
- **RUN, reads:**
  - rd_valid_o/rd_data_o come from registered state.
  - With bypass compiled in, a matching exe write overrides the read; the highest-index matching FU wins.
  - Commits never bypass.
- Reads in RUN are combinational from address to data.

## Timing
- INIT lasts NUM_PHYS_REG_P/INIT_PER_CYC_P cycles (16 at defaults). ready_o rises on the 16th rising edge after reset_n_i deasserts.
- Writes, commits, flags and mispredicts take effect in registered state on the next edge. flag_o is registered.
- Bypass is same-cycle.
- Reset asserted mid-INIT or mid-RUN returns to INIT immediately and restarts the scrub from 0.

## Configuration
- PHYS_REGFILE_BYPASS_EN defined: exe write data and valid are forwarded combinationally to read ports in the same cycle.
- PHYS_REGFILE_BYPASS_EN undefined: reads reflect registered state only, so write-to-read latency is 1 cycle. All other behaviour is identical.

## Test plan
1. **Reset/INIT:** release reset_n_i -> ready_o=0 for 16 cycles and rd_valid_o=0. After ready_o=1, a read of p3 returns valid=1, data=0; a read of p20 returns valid=0.
2. **Bypass:** exe_w_v_i[0]=1, addr=20, data=0xBEEF, rd_addr_i[0]=20 -> same cycle valid=1, data=0xBEEF with the macro defined; without the macro, valid=0 that cycle and valid=1, 0xBEEF the next cycle.
3. **Write collision:** FU0 and FU2 both write p30 with 0x1111 and 0x2222 -> p30=0x2222.
4. **Dual commit:** slot0 clears p5 and sets p20; slot1 clears p20 and sets p40, same cycle -> valid_arch p5=0, p20=0, p40=1.
5. **Mispredict:** p40 and p41 written valid; commit sets p40 in the same cycle as mispredict_i=1 -> next cycle p40 valid=1, p41 valid=0.
6. **Flags and mid-INIT reset:**
   - flag_o=0, then flag_v_i with mask=0101 and value=1111 -> flag_o=0101.
   - Assert reset at INIT cycle 7 -> ready_o stays 0 for 16 full cycles after release.
